// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and queue-depth helpers for pulse_stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHigh = 2'b01,
        StLow  = 2'b10
    } state_e;

    localparam int unsigned QUEUE_W_DEFAULT = 3;
    localparam int unsigned PEND_MAX        = (1 << QUEUE_W_DEFAULT) - 1;

    // Saturation value of a pending counter that is queue_w bits wide.
    function automatic int unsigned pend_max(input int unsigned queue_w);
        return (32'd1 << queue_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Strobe-in / stretched-level-out bundle for pulse_stretcher.
interface pulse_stretcher_if #(
    parameter int unsigned QUEUE_W = 3
) ();

    logic               trig;
    logic               level_out;
    logic               busy;
    logic [QUEUE_W-1:0] pending;
    logic               overflow;

    modport master (
        output trig,
        input  level_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  trig,
        output level_out,
        output busy,
        output pending,
        output overflow
    );

endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle trig strobes into HIGH_CYCLES-wide pulses with LOW_CYCLES guard gaps,
// replaying queued strobes in order. Define PULSE_STRETCH_RETRIG_EN to let trig extend a pulse.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned QUEUE_W     = 3
) (
    input logic              clk,
    input logic              reset,
    pulse_stretcher_if.slave bus
);

    localparam logic [CNT_W-1:0]   HighLoad = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LowLoad  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [QUEUE_W-1:0] PendMax  = QUEUE_W'(pend_max(QUEUE_W));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [QUEUE_W-1:0] pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               level_q, level_d;
    logic               busy_q, busy_d;
    logic               start, retrig, enq, deq, pend_nz;

    assign pend_nz = (pending_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        start      = 1'b0;
        retrig     = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.trig || pend_nz) begin
                    start = 1'b1;
                end
            end
            StHigh: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                retrig = bus.trig;
`endif
                if (retrig) begin
                    cnt_d = HighLoad;
                end else if (cnt_q == '0) begin
                    state_d = StLow;
                    cnt_d   = LowLoad;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLow: begin
                if (cnt_q == '0) begin
                    if (bus.trig || pend_nz) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d = StHigh;
            cnt_d   = HighLoad;
        end

        // A start serves the oldest queued request first; trig is consumed directly
        // only when nothing is waiting.
        deq = start && pend_nz;
        enq = bus.trig && !retrig && !(start && !pend_nz);

        if (enq && !deq) begin
            if (pending_q == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + QUEUE_W'(1);
            end
        end else if (deq && !enq) begin
            pending_d = pending_q - QUEUE_W'(1);
        end

        level_d = (state_d == StHigh);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: vector table, directed corner sequences and a
// randomized run against a pulse-schedule reference model.
module tb_pulse_stretcher;

    localparam int HC   = 4;
    localparam int LC   = 2;
    localparam int PMAX = 7;
`ifdef PULSE_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.QUEUE_W(3)) bus ();
    pulse_stretcher_if #(.QUEUE_W(2)) bus2 ();

    pulse_stretcher #(.HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_W(8), .QUEUE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pulse_stretcher #(.HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_W(8), .QUEUE_W(2)) dut_q2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic rst_n;
        logic trig;
        logic lvl;
        logic busy;
        int   pend;
    } vec_t;
    vec_t tbl[$];

    // Reference model: one record per accepted request (arrival edge, pulse start, pulse end).
    int m_arr[$];
    int m_st[$];
    int m_en[$];
    bit m_ovf;

    function automatic vec_t mk(logic r, logic t, logic l, logic b, int p);
        vec_t v;
        v.rst_n = r; v.trig = t; v.lvl = l; v.busy = b; v.pend = p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_arr.delete(); m_st.delete(); m_en.delete();
        m_ovf = 1'b0;
    endfunction

    // Request seen at the edge ending cycle k.
    function automatic void model_trig(int k);
        int n = m_st.size();
        int s;
        int q = 0;
        if (RETRIG) begin
            for (int i = 0; i < n; i++) begin
                if (m_st[i] <= k && k < m_en[i]) begin
                    m_en[i] = k + HC + 1;
                    for (int j = i + 1; j < n; j++) begin
                        m_st[j] = (m_arr[j] + 1 > m_en[j-1] + LC) ? m_arr[j] + 1 : m_en[j-1] + LC;
                        m_en[j] = m_st[j] + HC;
                    end
                    return;
                end
            end
        end
        s = k + 1;
        if (n > 0 && m_en[n-1] + LC > s) s = m_en[n-1] + LC;
        for (int i = 0; i < n; i++) if (m_st[i] > k + 1) q++;
        if (s > k + 1) q++;
        if (q > PMAX) begin
            m_ovf = 1'b1;
        end else begin
            m_arr.push_back(k); m_st.push_back(s); m_en.push_back(s + HC);
        end
    endfunction

    task automatic model_check(int c);
        int lvl = 0;
        int bsy = 0;
        int pnd = 0;
        for (int i = 0; i < m_st.size(); i++) begin
            if (m_st[i] <= c && c < m_en[i]) lvl = 1;
            if (m_st[i] <= c && c < m_en[i] + LC) bsy = 1;
            if (m_st[i] > c) pnd++;
        end
        chk("rnd_level", int'(bus.level_out), lvl);
        chk("rnd_busy", int'(bus.busy), bsy);
        chk("rnd_pending", int'(bus.pending), pnd);
        chk("rnd_overflow", int'(bus.overflow), int'(m_ovf));
    endtask

    initial begin
        bus.trig  = 1'b0;
        bus2.trig = 1'b0;
        reset     = 1'b0;
        repeat (3) tick();
        chk("rst_level", int'(bus.level_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_q2_busy", int'(bus2.busy), 0);

        // Single trig, then (plain build) three back-to-back trigs.
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0));
        if (!RETRIG) begin
            tbl.push_back(mk(1, 1, 1, 1, 0));
            tbl.push_back(mk(1, 1, 1, 1, 1));
            tbl.push_back(mk(1, 1, 1, 1, 2));
            tbl.push_back(mk(1, 0, 1, 1, 2));
            tbl.push_back(mk(1, 0, 0, 1, 2));
            tbl.push_back(mk(1, 0, 0, 1, 2));
            tbl.push_back(mk(1, 0, 1, 1, 1));
            for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 1, 1));
            tbl.push_back(mk(1, 0, 0, 1, 1));
            tbl.push_back(mk(1, 0, 0, 1, 1));
            for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 1, 1, 0));
            tbl.push_back(mk(1, 0, 0, 1, 0));
            tbl.push_back(mk(1, 0, 0, 1, 0));
            tbl.push_back(mk(1, 0, 0, 0, 0));
        end
        foreach (tbl[i]) begin
            bus.trig = tbl[i].trig;
            reset    = tbl[i].rst_n;
            tick();
            chk($sformatf("tbl%0d_level", i), int'(bus.level_out), int'(tbl[i].lvl));
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_pending", i), int'(bus.pending), tbl[i].pend);
        end
        bus.trig = 1'b0;
        reset    = 1'b1;

        // Trig on the LOW end cycle with one request queued: back-to-back pulse.
        bus.trig = 1'b1; tick();
        chk("lowend_first_level", int'(bus.level_out), 1);
        bus.trig = 1'b0; repeat (4) tick();
        chk("lowend_gap_level", int'(bus.level_out), 0);
        chk("lowend_gap_busy", int'(bus.busy), 1);
        bus.trig = 1'b1; tick();
        chk("lowend_queued", int'(bus.pending), 1);
        chk("lowend_end_busy", int'(bus.busy), 1);
        tick();
        chk("lowend_restart_level", int'(bus.level_out), 1);
        chk("lowend_restart_pending", int'(bus.pending), 1);
        bus.trig = 1'b0; repeat (20) tick();
        chk("lowend_drain_pending", int'(bus.pending), 0);
        chk("lowend_drain_busy", int'(bus.busy), 0);

        // Reset in the middle of a pulse with requests queued.
        bus.trig = 1'b1; repeat (3) tick();
        chk("midrst_pending_before", int'(bus.pending), RETRIG ? 0 : 2);
        chk("midrst_level_before", int'(bus.level_out), 1);
        bus.trig = 1'b0; reset = 1'b0; tick();
        chk("midrst_level", int'(bus.level_out), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_pending", int'(bus.pending), 0);
        chk("midrst_overflow", int'(bus.overflow), 0);
        reset = 1'b1; repeat (2) tick();
        chk("midrst_no_replay", int'(bus.busy), 0);

        // Two-bit queue: six consecutive trigs saturate and drop requests.
        begin
            int   pulses = 0;
            int   peak = 0;
            logic prev = 1'b0;
            for (int i = 0; i < 60; i++) begin
                bus2.trig = (i < 6);
                tick();
                if (bus2.level_out && !prev) pulses++;
                prev = bus2.level_out;
                if (int'(bus2.pending) > peak) peak = int'(bus2.pending);
            end
            chk("q2_pulses", pulses, RETRIG ? 1 : 4);
            chk("q2_peak_pending", peak, RETRIG ? 0 : 3);
            chk("q2_overflow", int'(bus2.overflow), RETRIG ? 0 : 1);
            chk("q2_idle", int'(bus2.busy), 0);
            reset = 1'b0; tick();
            chk("q2_overflow_cleared", int'(bus2.overflow), 0);
            reset = 1'b1; tick();
        end

        // Trig two cycles apart: one extended pulse with retrigger, two pulses without.
        bus.trig = 1'b1; tick();
        for (int i = 0; i < 12; i++) begin
            int el;
            int ep;
            el = RETRIG ? int'(i < 6) : int'(i < 4 || (i >= 6 && i < 10));
            ep = RETRIG ? 0 : int'(i >= 2 && i < 6);
            chk($sformatf("retrig%0d_level", i), int'(bus.level_out), el);
            chk($sformatf("retrig%0d_pending", i), int'(bus.pending), ep);
            bus.trig = (i == 1);
            tick();
        end

        // Randomized run against the reference model, at rising strobe density.
        for (int i = 0; i < 3000; i++) begin
            logic t;
            logic r;
            int   dens;
            dens = (i < 1000) ? 15 : (i < 2000) ? 45 : 85;
            r = (i != 0) && ($urandom_range(0, 299) != 0);
            t = ($urandom_range(0, 99) < dens);
            bus.trig = t;
            reset    = r;
            if (!r) model_reset();
            else if (t) model_trig(cyc);
            tick();
            model_check(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
